// File: rtl/grid_io_pkg.sv
// grid_io_pkg: per-pad configuration layout shared by the I/O bank and its pads.
package grid_io_pkg;
  localparam int IO_CFG_BITS = 3;
  localparam int CFG_OE      = 0;
  localparam int CFG_OUT_REG = 1;
  localparam int CFG_IN_REG  = 2;
  typedef struct packed {
    logic in_reg;
    logic out_reg;
    logic oe;
  } pad_cfg_t;
  function automatic pad_cfg_t unpack_cfg(input logic [IO_CFG_BITS-1:0] b);
    return '{in_reg: b[CFG_IN_REG], out_reg: b[CFG_OUT_REG], oe: b[CFG_OE]};
  endfunction
endpackage

// File: rtl/grid_io_pad.sv
// grid_io_pad: single pad data path with optional output/input registering.
module grid_io_pad
  import grid_io_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  pad_cfg_t cfg,
  input  logic     io_outpad,
  input  logic     gpio_in,
  output logic     io_inpad,
  output logic     gpio_out,
  output logic     gpio_oe
);
  logic out_q, in_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= 1'b0;
      in_q  <= 1'b0;
    end else begin
      out_q <= io_outpad;
      in_q  <= gpio_in;
    end
  end
  // a driving pad never echoes the receive value back into the fabric
  always_comb begin
    gpio_oe  = cfg.oe;
    gpio_out = cfg.out_reg ? out_q : io_outpad;
    io_inpad = cfg.oe ? 1'b0 : (cfg.in_reg ? in_q : gpio_in);
  end
endmodule

// File: rtl/grid_io_bank.sv
// grid_io_bank: configuration shift chain with commit-to-active shadowing, feeding NUM_PADS pad slices.
module grid_io_bank
  import grid_io_pkg::*;
#(
  parameter  int NUM_PADS  = 8,
  localparam int CHAIN_LEN = NUM_PADS * IO_CFG_BITS
) (
  input  logic                prog_clk,
  input  logic                pReset,
  input  logic                ccff_head,
  input  logic                ccff_en,
  input  logic                ccff_commit,
  output logic                ccff_tail,
  output logic                cfg_done,
  output logic                cfg_err,
  input  logic [NUM_PADS-1:0] io_outpad,
  output logic [NUM_PADS-1:0] io_inpad,
  input  logic [NUM_PADS-1:0] gpio_in,
  output logic [NUM_PADS-1:0] gpio_out,
  output logic [NUM_PADS-1:0] gpio_oe
);
  localparam int CW = $clog2(CHAIN_LEN + 1);
  logic [CHAIN_LEN-1:0] sr, act;
  logic [CW-1:0]        cnt;
  logic                 commit_ok;
  always_comb begin
    cfg_done  = (cnt == CW'(CHAIN_LEN));
    ccff_tail = sr[CHAIN_LEN-1];
    commit_ok = ccff_commit && cfg_done;
  end
  // commit captures the pre-shift chain even when a shift happens on the same edge
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      sr      <= '0;
      act     <= '0;
      cnt     <= '0;
      cfg_err <= 1'b0;
    end else begin
      if (ccff_en) sr <= {sr[CHAIN_LEN-2:0], ccff_head};
      if (commit_ok) act <= sr;
      cnt <= commit_ok ? CW'(ccff_en) : (ccff_en && !cfg_done) ? cnt + 1'b1 : cnt;
      if (ccff_commit && !cfg_done) cfg_err <= 1'b1;
    end
  end
  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    grid_io_pad u_pad (
      .clk       (prog_clk),
      .rst       (pReset),
      .cfg       (unpack_cfg(act[IO_CFG_BITS*p +: IO_CFG_BITS])),
      .io_outpad (io_outpad[p]),
      .gpio_in   (gpio_in[p]),
      .io_inpad  (io_inpad[p]),
      .gpio_out  (gpio_out[p]),
      .gpio_oe   (gpio_oe[p])
    );
  end
endmodule
